csr_access_sequencer: RTL and testbench
=======================================

// Module: csr_access_sequencer
// PURPOSE
//  Executes Zicsr instructions (CSRRW/S/C, CSRRWI/SI/CI) as a read-modify-write sequence on the CSR port.
//  Sits between decode/execute and the CSR file. Reads arrive already masked by the CSR masking logic.
//  Raw write data is sent to the CSR port, and the masking logic on that port applies WARL/WPRI/PMP-lock rules.
//  Stalls the pipeline while the sequence is in flight and returns the old value for writeback to rd.
// PARAMETERS
//  XLEN         2'b10  width code (2'b01 = 32b, 2'b10 = 64b); W = 1<<(XLEN+4)
//  ACK_TIMEOUT  15     maximum cycles a request waits for its ack before the access is aborted as illegal
// PORTS
//  i_clk          in   1   clock; all state updates on rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_valid        in   1   CSR instruction present; accepted when i_valid & o_ready
//  o_ready        out  1   sequencer idle, can accept an instruction
//  i_funct3       in   3   instruction funct3
//  i_csr_addr     in   12  CSR address
//  i_rs1_val      in   W   rs1 register value (register forms)
//  i_rs1_idx      in   5   rs1 index, or zimm for the immediate forms
//  i_rd_idx       in   5   destination register index
//  o_csr_addr     out  12  address for current access (latched)
//  o_csr_rd_req   out  1   read request; held until i_csr_rd_ack
//  i_csr_rd_ack   in   1   read complete; i_csr_rd_data valid this cycle
//  i_csr_rd_data  in   W   masked old CSR value
//  o_csr_wr_req   out  1   write request; held until i_csr_wr_ack
//  o_csr_wr_data  out  W   unmasked new value
//  i_csr_wr_ack   in   1   write accepted
//  o_stall        out  1   pipeline hold; high in every state except IDLE
//  o_done         out  1   one-cycle completion pulse
//  o_illegal      out  1   illegal-instruction flag; valid with o_done
//  o_rd_we        out  1   rd writeback enable; valid with o_done
//  o_rd_idx       out  5   rd index; valid with o_done
//  o_rd_data      out  W   old CSR value; valid with o_done
// BEHAVIOUR
//  Reset: state = IDLE, timeout counter = 0. All outputs 0 except o_ready = 1. Reset mid-operation drops any pending req at once.
//  States: IDLE -> RD -> WR -> RESP -> IDLE. RD and WR are skipped per the rules below.
//  Accept (IDLE, i_valid): latch funct3, addr, rd_idx, rs1_idx and src.
//    src = funct3[2] ? {zeros, i_rs1_idx} : i_rs1_val.
//  do_write = (funct3[1:0] == 2'b01) | (i_rs1_idx != 0).
//  do_read  = (funct3[1:0] != 2'b01) | (i_rd_idx != 0).
//  Illegal at accept (go straight to RESP, no port request): any of
//    - funct3[1:0] == 2'b00;
//    - do_write & (addr[11:10] == 2'b11) (read-only CSR).
//  After accept: go to RD if do_read, else WR.
//  RD: o_csr_rd_req = 1. On ack, latch old = i_csr_rd_data. Then go to WR if do_write, else RESP.
//  WR: o_csr_wr_req = 1. o_csr_wr_data by funct3[1:0]:
//    - 01 -> src
//    - 10 -> old | src
//    - 11 -> old & ~src
//    On ack, go to RESP.
//  Ack sampled only while the matching req is high. Acks outside RD/WR are ignored.
//  Timeout: counter clears on entering RD or WR and increments each cycle without ack.
//    When counter == ACK_TIMEOUT: drop req, set illegal, go to RESP. No write is issued after a read timeout.
//  RESP (one cycle):
//    - o_done = 1, o_illegal = latched flag.
//    - o_rd_we = do_read & !illegal & (rd_idx != 0); o_rd_data = old; o_rd_idx = rd_idx.
//  Outputs are registered. o_done, o_rd_we and o_illegal are 0 outside RESP.
//  Minimum latency with both accesses acked in their first cycle: accept at cycle 0, o_done at cycle 3.
//  XLEN = 2'b01: all W-wide datapaths are 32 bits, and zimm is zero-extended to 32 bits.
// TESTING
//  CSRRW addr 0x340, rs1_val 0xDEAD, rd=5, immediate acks -> rd_req c1, wr_req c2 data 0xDEAD, done c3, rd_we=1 data=old.
//  CSRRS rs1_idx=0, rd=3, old 0x88 -> no wr_req ever, done c2, rd_data 0x88, rd_we=1.
//  CSRRCI zimm=5'h03, old 0xFF -> wr_data 0xFC; CSRRWI rd=0 -> no rd_req, rd_we=0.
//  CSRRW to addr 0xF14 -> no port request, done c1, illegal=1, rd_we=0.
//  rd_ack withheld 15 cycles -> rd_req drops, illegal=1 on done, wr_req never asserted.
//  Assert i_rst_n low mid-WR -> wr_req, stall, done 0 immediately; o_ready 1 after release.

Source files
------------

// File: rtl/csr_access_sequencer_if.sv
// Bundles the instruction-side handshake, the CSR port and the writeback
// results of the CSR access sequencer.
//   slave  : the sequencer's view (takes instructions, masters the CSR port)
//   master : the environment's view (issues instructions, answers the CSR port)
// Signals:
//   valid/ready, funct3, csr_addr, rs1_val, rs1_idx, rd_idx : instruction in
//   port_addr, rd_req/rd_ack/csr_rd_data, wr_req/wr_data/wr_ack : CSR port
//   stall, done, illegal, wb_we, wb_idx, wb_data : pipeline hold and result
interface csr_access_sequencer_if #(
  parameter int unsigned W = 64
);
  logic         valid;
  logic         ready;
  logic [2:0]   funct3;
  logic [11:0]  csr_addr;
  logic [W-1:0] rs1_val;
  logic [4:0]   rs1_idx;
  logic [4:0]   rd_idx;

  logic [11:0]  port_addr;
  logic         rd_req;
  logic         rd_ack;
  logic [W-1:0] csr_rd_data;
  logic         wr_req;
  logic [W-1:0] wr_data;
  logic         wr_ack;

  logic         stall;
  logic         done;
  logic         illegal;
  logic         wb_we;
  logic [4:0]   wb_idx;
  logic [W-1:0] wb_data;

  modport slave (
    input  valid, funct3, csr_addr, rs1_val, rs1_idx, rd_idx,
    input  rd_ack, csr_rd_data, wr_ack,
    output ready, port_addr, rd_req, wr_req, wr_data,
    output stall, done, illegal, wb_we, wb_idx, wb_data
  );

  modport master (
    output valid, funct3, csr_addr, rs1_val, rs1_idx, rd_idx,
    output rd_ack, csr_rd_data, wr_ack,
    input  ready, port_addr, rd_req, wr_req, wr_data,
    input  stall, done, illegal, wb_we, wb_idx, wb_data
  );
endinterface

// File: rtl/csr_access_sequencer.sv
// Runs a Zicsr instruction (CSRRW/S/C and the immediate forms) as a
// read-modify-write sequence on the CSR port and returns the old value for rd.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : csr_access_sequencer_if.slave (instruction in, CSR port, result)
// Parameters:
//   Xlen       : width code, 2'b01 = 32 bit, 2'b10 = 64 bit
//   AckTimeout : cycles a request waits for its ack before aborting as illegal
module csr_access_sequencer #(
  parameter logic [1:0]  Xlen       = 2'b10,
  parameter int unsigned AckTimeout = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  csr_access_sequencer_if.slave bus
);
  localparam int unsigned W    = 32'd1 << (int'(Xlen) + 4);
  localparam int unsigned CntW = (AckTimeout < 1) ? 1 : $clog2(AckTimeout + 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic            do_write_q, do_read_q;
  logic [4:0]      rd_idx_q;
  logic [W-1:0]    src_q, old_q;
  logic [CntW-1:0] cnt_q;
  logic [11:0]     addr_q;
  logic            rd_req_q, wr_req_q;
  logic [W-1:0]    wr_data_q;
  logic            ready_q, stall_q, done_q, illegal_q, wb_we_q;

  // Decode of the instruction currently offered on the input side.
  logic [1:0]   acc_op;
  logic         acc_write, acc_read, acc_illegal, timeout;
  logic [W-1:0] acc_src, rd_merged;

  function automatic logic [W-1:0] merge(input logic [1:0]   op,
                                         input logic [W-1:0] old,
                                         input logic [W-1:0] src);
    case (op)
      2'b10:   return old | src;
      2'b11:   return old & ~src;
      default: return src;
    endcase
  endfunction

  always_comb begin
    acc_op      = bus.funct3[1:0];
    acc_write   = (acc_op == 2'b01) | (bus.rs1_idx != 5'd0);
    acc_read    = (acc_op != 2'b01) | (bus.rd_idx != 5'd0);
    acc_src     = bus.funct3[2] ? W'(bus.rs1_idx) : bus.rs1_val;
    // Writes to the 0b11 address quadrant target read-only CSRs.
    acc_illegal = (acc_op == 2'b00) | (acc_write & (bus.csr_addr[11:10] == 2'b11));
    rd_merged   = merge(op_q, bus.csr_rd_data, src_q);
    timeout     = (cnt_q == CntW'(AckTimeout));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      do_write_q <= 1'b0;
      do_read_q  <= 1'b0;
      rd_idx_q   <= 5'd0;
      src_q      <= '0;
      old_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= 12'd0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      ready_q    <= 1'b1;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      wb_we_q    <= 1'b0;
    end else begin
      // Result flags are single-cycle pulses raised only on entry to StResp.
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      wb_we_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.valid) begin
            op_q       <= acc_op;
            do_write_q <= acc_write;
            do_read_q  <= acc_read;
            rd_idx_q   <= bus.rd_idx;
            src_q      <= acc_src;
            addr_q     <= bus.csr_addr;
            old_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            stall_q    <= 1'b1;
            if (acc_illegal) begin
              state_q   <= StResp;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else if (acc_read) begin
              state_q  <= StRd;
              rd_req_q <= 1'b1;
            end else begin
              // No read means a plain CSRRW(I), so the new value is just src.
              state_q   <= StWr;
              wr_req_q  <= 1'b1;
              wr_data_q <= acc_src;
            end
          end
        end
        StRd: begin
          if (bus.rd_ack) begin
            old_q    <= bus.csr_rd_data;
            rd_req_q <= 1'b0;
            if (do_write_q) begin
              state_q   <= StWr;
              wr_req_q  <= 1'b1;
              wr_data_q <= rd_merged;
              cnt_q     <= '0;
            end else begin
              state_q <= StResp;
              done_q  <= 1'b1;
              wb_we_q <= (rd_idx_q != 5'd0);
            end
          end else if (timeout) begin
            state_q   <= StResp;
            rd_req_q  <= 1'b0;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWr: begin
          if (bus.wr_ack) begin
            state_q  <= StResp;
            wr_req_q <= 1'b0;
            done_q   <= 1'b1;
            wb_we_q  <= do_read_q & (rd_idx_q != 5'd0);
          end else if (timeout) begin
            state_q   <= StResp;
            wr_req_q  <= 1'b0;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.port_addr = addr_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.stall     = stall_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_idx    = rd_idx_q;
  assign bus.wb_data   = old_q;
endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench: the issuing process pushes the expected outcome of each
// instruction, a CSR-port responder answers requests with scripted delays,
// and a monitor pops and compares whenever done pulses.
module tb_csr_access_sequencer;
  localparam int W     = 64;
  localparam int T     = 15;
  localparam int NEVER = 255;

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [63:0] rs1_val;
    logic [4:0]  rs1_idx;
    logic [4:0]  rd_idx;
    logic [63:0] old;
    int          rd_dly;
    int          wr_dly;
  } txn_t;

  typedef struct {
    int          lat;
    bit          saw_rd;
    bit          saw_wr;
    logic [63:0] wr_data;
    logic [11:0] addr;
    bit          ill;
    bit          we;
    logic [4:0]  rd_idx;
    logic [63:0] rd_data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  csr_access_sequencer_if #(.W(W)) bus ();

  csr_access_sequencer #(
    .Xlen       (2'b10),
    .AckTimeout (T)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  txn_t cur;
  bit          saw_rd, saw_wr;
  logic [63:0] seen_wr_data;
  logic [11:0] seen_addr;
  int          cyc = 0;
  int          acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference outcome computed directly from the instruction semantics.
  function automatic exp_t model(input txn_t t);
    exp_t        e;
    logic [1:0]  op;
    bit          dw, dr;
    logic [63:0] src, old;
    op  = t.f3[1:0];
    dw  = (op == 2'b01) || (t.rs1_idx != 0);
    dr  = (op != 2'b01) || (t.rd_idx != 0);
    src = t.f3[2] ? {59'd0, t.rs1_idx} : t.rs1_val;
    e = '{lat: 1, saw_rd: 0, saw_wr: 0, wr_data: 0, addr: t.addr, ill: 0, we: 0,
          rd_idx: t.rd_idx, rd_data: 0};
    if (op == 2'b00 || (dw && t.addr[11:10] == 2'b11)) begin
      e.ill = 1;
      return e;
    end
    old = 0;
    if (dr) begin
      e.saw_rd = 1;
      if (t.rd_dly == NEVER) begin
        e.lat += T + 1;
        e.ill = 1;
      end else begin
        e.lat += t.rd_dly + 1;
        old = t.old;
      end
    end
    if (dw && !e.ill) begin
      e.saw_wr  = 1;
      e.wr_data = (op == 2'b01) ? src : (op == 2'b10) ? (old | src) : (old & ~src);
      if (t.wr_dly == NEVER) begin
        e.lat += T + 1;
        e.ill = 1;
      end else begin
        e.lat += t.wr_dly + 1;
      end
    end
    e.we      = dr && !e.ill && (t.rd_idx != 0);
    e.rd_data = old;
    return e;
  endfunction

  function automatic txn_t mk(input logic [2:0] f3, input logic [11:0] addr,
                              input logic [63:0] rs1_val, input logic [4:0] rs1_idx,
                              input logic [4:0] rd_idx, input logic [63:0] old,
                              input int rd_dly, input int wr_dly);
    txn_t t;
    t = '{f3: f3, addr: addr, rs1_val: rs1_val, rs1_idx: rs1_idx, rd_idx: rd_idx,
          old: old, rd_dly: rd_dly, wr_dly: wr_dly};
    return t;
  endfunction

  task automatic wait_ready();
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: ready stuck at %b, required 1", bus.ready);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "sequencer never returned to idle");
    end
  endtask

  task automatic issue(input txn_t t, input bit push);
    wait_ready();
    if (push) exp_q.push_back(model(t));
    cur          = t;
    saw_rd       = 0;
    saw_wr       = 0;
    bus.funct3   = t.f3;
    bus.csr_addr = t.addr;
    bus.rs1_val  = t.rs1_val;
    bus.rs1_idx  = t.rs1_idx;
    bus.rd_idx   = t.rd_idx;
    bus.valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.valid    = 1'b0;
    bus.rs1_val  = rnd64();
  endtask

  // CSR port responder: ack after a scripted number of request cycles, random noise otherwise.
  initial begin
    int rd_cnt = 0;
    int wr_cnt = 0;
    bus.rd_ack = 0;
    bus.wr_ack = 0;
    bus.csr_rd_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
        bus.rd_ack = 0;
        bus.wr_ack = 0;
      end else begin
        if (bus.rd_req) begin
          saw_rd          = 1;
          seen_addr       = bus.port_addr;
          bus.rd_ack      = (cur.rd_dly != NEVER) && (rd_cnt == cur.rd_dly);
          bus.csr_rd_data = bus.rd_ack ? cur.old : rnd64();
          rd_cnt++;
        end else begin
          rd_cnt          = 0;
          bus.rd_ack      = 1'($urandom_range(0, 1));
          bus.csr_rd_data = rnd64();
        end
        if (bus.wr_req) begin
          saw_wr       = 1;
          seen_addr    = bus.port_addr;
          seen_wr_data = bus.wr_data;
          bus.wr_ack   = (cur.wr_dly != NEVER) && (wr_cnt == cur.wr_dly);
          wr_cnt++;
        end else begin
          wr_cnt     = 0;
          bus.wr_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: latency measured from the accepting cycle, results popped on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.valid && bus.ready) acc_cyc = cyc;
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          chk("illegal", bus.illegal, e.ill);
          chk("rd_we", bus.wb_we, e.we);
          chk("rd_idx", bus.wb_idx, e.rd_idx);
          chk("saw_rd_req", saw_rd, e.saw_rd);
          chk("saw_wr_req", saw_wr, e.saw_wr);
          if (e.saw_wr) chk("wr_data", seen_wr_data, e.wr_data);
          if (e.saw_rd || e.saw_wr) chk("port_addr", seen_addr, e.addr);
          if (e.we) chk("rd_data", bus.wb_data, e.rd_data);
        end
      end
    end
  end

  initial begin
    txn_t t;
    bus.valid    = 0;
    bus.funct3   = 0;
    bus.csr_addr = 0;
    bus.rs1_val  = 0;
    bus.rs1_idx  = 0;
    bus.rd_idx   = 0;
    cur = mk(3'b001, 12'h0, 64'h0, 5'd0, 5'd0, 64'h0, 0, 0);
    #1 rst_n = 0;
    #20;
    chk("reset_ready", bus.ready, 1);
    chk("reset_stall", bus.stall, 0);
    chk("reset_rd_req", bus.rd_req, 0);
    chk("reset_wr_req", bus.wr_req, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_illegal", bus.illegal, 0);
    chk("reset_rd_we", bus.wb_we, 0);
    chk("reset_port_addr", bus.port_addr, 0);
    @(posedge clk);
    #1 rst_n = 1;

    // Directed cases.
    issue(mk(3'b001, 12'h340, 64'hDEAD, 5'd7, 5'd5, 64'h1234_5678_9ABC_DEF0, 0, 0), 1);
    issue(mk(3'b010, 12'h300, 64'hFFFF, 5'd0, 5'd3, 64'h88, 0, 0), 1);
    issue(mk(3'b111, 12'h305, 64'h0, 5'h03, 5'd1, 64'hFF, 0, 0), 1);
    issue(mk(3'b101, 12'h341, 64'h0, 5'h09, 5'd0, 64'h55, 0, 0), 1);
    issue(mk(3'b001, 12'hF14, 64'h1, 5'd2, 5'd4, 64'h0, 0, 0), 1);
    issue(mk(3'b010, 12'h300, 64'h3, 5'd1, 5'd6, 64'h7, NEVER, 0), 1);
    issue(mk(3'b000, 12'h300, 64'h3, 5'd1, 5'd6, 64'h7, 0, 0), 1);
    issue(mk(3'b010, 12'hF14, 64'h3, 5'd0, 5'd8, 64'hABCD, 1, 0), 1);
    issue(mk(3'b011, 12'h300, 64'h30, 5'd9, 5'd2, 64'hF0, 2, NEVER), 1);
    issue(mk(3'b001, 12'h7C0, 64'h5A5A, 5'd1, 5'd1, 64'h1, 14, 3), 1);

    // Reset in the middle of a write: requests and stall drop at once.
    issue(mk(3'b001, 12'h340, 64'h1111, 5'd4, 5'd5, 64'h22, 0, NEVER), 0);
    for (int k = 0; k < 20 && bus.wr_req !== 1'b1; k++) @(negedge clk);
    chk("mid_wr_req_seen", bus.wr_req, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_wr_req", bus.wr_req, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_done", bus.done, 0);
    @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("post_rst_ready", bus.ready, 1);

    // Randomized instructions.
    for (int n = 0; n < 80; n++) begin
      int          r;
      logic [2:0]  f3;
      logic [11:0] addr;
      r    = $urandom_range(0, 15);
      f3   = (r == 0) ? 3'b000 : (r == 1) ? 3'b100 : 3'($urandom_range(0, 7));
      if (f3[1:0] == 2'b00 && r > 1) f3[0] = 1'b1;
      addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
      t = mk(f3, addr, rnd64(),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             rnd64(),
             ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4)),
             ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4)));
      issue(t, 1);
    end

    wait_ready();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
